reg_access_ctrl: RTL and testbench
==================================

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter ALU_TIMEOUT, default 15: maximum WAIT cycles without AluDone before the operation aborts.
REQ-002 SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port RstN, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port InstValid, input, 1 bit: instruction offered.
REQ-005 SHALL have port InstReady, output, 1 bit: controller can accept an instruction.
REQ-006 SHALL have ports InstRs and InstRt, input, 5 bits each: source register numbers.
REQ-007 SHALL have port InstRd, input, 5 bits: destination register number.
REQ-008 SHALL have port InstOp, input, 3 bits: ALU opcode.
REQ-009 SHALL have ports ReadRegNum1 and ReadRegNum2, output, 5 bits each: register-file read addresses.
REQ-010 SHALL have ports ReadOut1 and ReadOut2, input, 32 bits each: register-file read data, combinational from the addresses.
REQ-011 SHALL have ports AluA and AluB, output, 32 bits each: captured operands.
REQ-012 SHALL have port AluOp, output, 3 bits: latched opcode.
REQ-013 SHALL have port AluStart, output, 1 bit: one-cycle start pulse.
REQ-014 SHALL have port AluResult, input, 32 bits: ALU result.
REQ-015 SHALL have port AluDone, input, 1 bit: result valid.
REQ-016 SHALL have port WriteEn, output, 1 bit: register-file write strobe.
REQ-017 SHALL have port WriteRegNum, output, 5 bits: write address.
REQ-018 SHALL have port RegData, output, 32 bits: write data.
REQ-019 SHALL have port Error, output, 1 bit: one-cycle pulse on ALU timeout.

Function
REQ-020 SHALL implement states IDLE, READ, EXEC, WAIT and WB.
REQ-021 SHALL drive InstReady=1 only in IDLE; InstValid&InstReady at an edge latches Rs/Rt/Rd/Op and moves to READ.
REQ-022 SHALL drive ReadRegNum1/2 from the latched Rs/Rt continuously; in READ, it captures ReadOut1/2 into AluA/AluB at the edge and moves to EXEC.
REQ-023 SHALL assert AluStart for exactly the one EXEC cycle, clear the timeout counter and move to WAIT.
REQ-024 SHALL, in WAIT with AluDone=1, capture AluResult into RegData and move to WB.
REQ-025 SHALL, in WAIT with AluDone=0, increment the counter; after ALU_TIMEOUT such cycles it pulses Error for one cycle, returns to IDLE and performs no write.
REQ-026 SHALL, if AluDone and the final timeout cycle coincide, treat AluDone as winning: no Error, write proceeds.
REQ-027 SHALL, in WB, assert WriteEn for exactly one cycle with WriteRegNum=latched Rd and return to IDLE.
REQ-028 SHALL produce the minimum latency of accept edge N, AluStart in cycle N+2, WriteEn in cycle N+4 (AluDone in the first WAIT cycle), giving a maximum throughput of one instruction per 5 cycles.
REQ-029 SHALL ignore InstValid while not in IDLE, and SHALL ignore AluDone outside WAIT.
REQ-030 SHALL hold AluA/AluB/AluOp/RegData stable until the next capture.

Reset
REQ-031 SHALL, while RstN=0, force state IDLE and hold AluA, AluB, RegData=0, AluOp, WriteRegNum=0, AluStart, WriteEn, Error=0, latched register numbers=0 and the counter=0, regardless of Clk.
REQ-032 SHALL, on RstN assertion mid-operation, abandon the instruction with no WriteEn and no Error pulse; InstReady=1 in the first cycle after deassertion.

Configuration
REQ-033 SHALL, with macro ZERO_REG_ENABLE_EN defined, force a captured operand to 0 when its source register is 0, and SHALL go WAIT->IDLE with no WriteEn when Rd=0.
REQ-034 SHALL, without ZERO_REG_ENABLE_EN, treat register 0 like any other register for both reads and writes.

Verification
REQ-035 SHALL cover basic op: Rs=1 (ReadOut1=5), Rt=2 (ReadOut2=7), Rd=3, AluResult=12 with AluDone on the first WAIT cycle -> AluA=5, AluB=7, WriteEn one cycle at N+4, WriteRegNum=3, RegData=12.
REQ-036 SHALL cover timeout: ALU_TIMEOUT=15, AluDone never asserted -> Error pulse after 15 WAIT cycles, no WriteEn, InstReady=1 next cycle.
REQ-037 SHALL cover coincidence: AluDone on the 15th WAIT cycle -> no Error, WriteEn asserted.
REQ-038 SHALL cover back-pressure: InstValid held high during an operation -> second instruction accepted only at the next IDLE edge, exactly one accept per instruction.
REQ-039 SHALL cover reset mid-WAIT: RstN=0 -> all outputs 0 immediately, no WriteEn after release.
REQ-040 SHALL cover ZERO_REG_ENABLE_EN defined: Rs=0 with ReadOut1=0xFFFFFFFF -> AluA=0; Rd=0 -> no WriteEn.

Source files
------------

// File: rtl/reg_access_ctrl.sv
// reg_access_ctrl: sequences one register-to-register ALU instruction at a time
// through IDLE -> READ -> EXEC -> WAIT -> WB. It fetches the operands, starts the
// ALU, waits for its result with a bounded timeout, and then writes the result back.
// Optional feature: define ZERO_REG_ENABLE_EN to make register 0 a hard zero.
// With the macro set, register 0 reads as 0 and a write to register 0 is dropped.
// ALU_TIMEOUT must be at least 1.
module reg_access_ctrl #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        InstValid,
  output logic        InstReady,
  input  logic [4:0]  InstRs,
  input  logic [4:0]  InstRt,
  input  logic [4:0]  InstRd,
  input  logic [2:0]  InstOp,
  output logic [4:0]  ReadRegNum1,
  output logic [4:0]  ReadRegNum2,
  input  logic [31:0] ReadOut1,
  input  logic [31:0] ReadOut2,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [2:0]  AluOp,
  output logic        AluStart,
  input  logic [31:0] AluResult,
  input  logic        AluDone,
  output logic        WriteEn,
  output logic [4:0]  WriteRegNum,
  output logic [31:0] RegData,
  output logic        Error
);

  // The counter must be able to hold ALU_TIMEOUT itself, because it steps once
  // more on the final WAIT cycle.
  localparam int CW = (ALU_TIMEOUT < 2) ? 1 : $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(ALU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WAIT,
    ST_WB
  } state_t;

  state_t          state_reg, state_next;
  logic [4:0]      rs_reg, rt_reg, rd_reg;
  logic [2:0]      op_reg;
  logic [31:0]     alu_a_reg, alu_b_reg, reg_data_reg;
  logic [CW-1:0]   count_reg;
  logic [31:0]     operand_a, operand_b;
  logic            timeout_hit;
  logic            accept;

  assign accept = InstValid && (state_reg == ST_IDLE);

  // Operand selection: register 0 is optionally a hard zero.
`ifdef ZERO_REG_ENABLE_EN
  assign operand_a = (rs_reg == 5'd0) ? 32'd0 : ReadOut1;
  assign operand_b = (rt_reg == 5'd0) ? 32'd0 : ReadOut2;
`else
  assign operand_a = ReadOut1;
  assign operand_b = ReadOut2;
`endif

  // State register.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. When AluDone arrives on the last permitted WAIT cycle,
  // AluDone takes priority over the timeout.
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (InstValid) begin
          state_next = ST_READ;
        end
      end
      ST_READ: state_next = ST_EXEC;
      ST_EXEC: state_next = ST_WAIT;
      ST_WAIT: begin
        if (AluDone) begin
`ifdef ZERO_REG_ENABLE_EN
          state_next = (rd_reg == 5'd0) ? ST_IDLE : ST_WB;
`else
          state_next = ST_WB;
`endif
        end else if (count_reg == LAST_WAIT) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_WB:   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: instruction latch, operand capture, timeout counter and result capture.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rs_reg       <= 5'd0;
      rt_reg       <= 5'd0;
      rd_reg       <= 5'd0;
      op_reg       <= 3'd0;
      alu_a_reg    <= 32'd0;
      alu_b_reg    <= 32'd0;
      reg_data_reg <= 32'd0;
      count_reg    <= '0;
    end else begin
      if (accept) begin
        rs_reg <= InstRs;
        rt_reg <= InstRt;
        rd_reg <= InstRd;
        op_reg <= InstOp;
      end
      if (state_reg == ST_READ) begin
        alu_a_reg <= operand_a;
        alu_b_reg <= operand_b;
      end
      if (state_reg == ST_EXEC) begin
        count_reg <= '0;
      end
      if (state_reg == ST_WAIT) begin
        if (AluDone) begin
          reg_data_reg <= AluResult;
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  // The strobes are decoded from the registered state, so each one lasts exactly one cycle.
  assign InstReady   = (state_reg == ST_IDLE);
  assign AluStart    = (state_reg == ST_EXEC);
  assign WriteEn     = (state_reg == ST_WB);
  assign Error       = timeout_hit;
  assign ReadRegNum1 = rs_reg;
  assign ReadRegNum2 = rt_reg;
  assign WriteRegNum = rd_reg;
  assign AluOp       = op_reg;
  assign AluA        = alu_a_reg;
  assign AluB        = alu_b_reg;
  assign RegData     = reg_data_reg;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl. It models the register file in the bench.
// The zero-register expectations follow ZERO_REG_ENABLE_EN.
module tb_reg_access_ctrl;

  localparam int TO = 15;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        InstValid;
  logic        InstReady;
  logic [4:0]  InstRs, InstRt, InstRd;
  logic [2:0]  InstOp;
  logic [4:0]  ReadRegNum1, ReadRegNum2;
  logic [31:0] ReadOut1, ReadOut2;
  logic [31:0] AluA, AluB;
  logic [2:0]  AluOp;
  logic        AluStart;
  logic [31:0] AluResult;
  logic        AluDone;
  logic        WriteEn;
  logic [4:0]  WriteRegNum;
  logic [31:0] RegData;
  logic        Error;

  logic [31:0] rf [32];
  int n_cmp = 0;
  int n_bad = 0;
  int accept_cnt = 0;

  reg_access_ctrl #(.ALU_TIMEOUT(TO)) dut (
    .Clk(Clk), .RstN(RstN),
    .InstValid(InstValid), .InstReady(InstReady),
    .InstRs(InstRs), .InstRt(InstRt), .InstRd(InstRd), .InstOp(InstOp),
    .ReadRegNum1(ReadRegNum1), .ReadRegNum2(ReadRegNum2),
    .ReadOut1(ReadOut1), .ReadOut2(ReadOut2),
    .AluA(AluA), .AluB(AluB), .AluOp(AluOp), .AluStart(AluStart),
    .AluResult(AluResult), .AluDone(AluDone),
    .WriteEn(WriteEn), .WriteRegNum(WriteRegNum), .RegData(RegData),
    .Error(Error)
  );

  always #5 Clk = ~Clk;

  assign ReadOut1 = rf[ReadRegNum1];
  assign ReadOut2 = rf[ReadRegNum2];

  // Count handshakes so that back-pressure can be checked.
  always @(posedge Clk) begin
    if (RstN && InstValid && InstReady) accept_cnt <= accept_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Run one instruction, starting at posedge+2 of an IDLE cycle.
  // done_at is the WAIT cycle (1-based) on which AluDone is raised; 0 means never.
  task automatic do_op(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [2:0] op, input logic [31:0] res,
                       input int done_at, input logic [31:0] exp_a, input logic [31:0] exp_b,
                       input logic exp_we, input logic exp_err);
    logic saw_err;
    saw_err = 1'b0;
    InstValid = 1'b1; InstRs = rs; InstRt = rt; InstRd = rd; InstOp = op;
    #1 check({tag, ".ready_idle"}, InstReady, 1'b1);
    @(posedge Clk); #1;                                   // accept edge N
    InstValid = 1'b0; InstRs = 5'd31; InstRt = 5'd30; InstRd = 5'd29; InstOp = 3'd7;
    #1 check({tag, ".ready_read"}, InstReady, 1'b0);
    check({tag, ".rnum1"}, ReadRegNum1, rs);
    check({tag, ".rnum2"}, ReadRegNum2, rt);
    @(posedge Clk); #2;                                   // cycle N+2: EXEC
    check({tag, ".start"}, AluStart, 1'b1);
    check({tag, ".alua"}, AluA, exp_a);
    check({tag, ".alub"}, AluB, exp_b);
    check({tag, ".aluop"}, AluOp, op);
    for (int k = 1; k <= TO; k++) begin
      @(posedge Clk); #1;
      AluDone = (k == done_at);
      AluResult = (k == done_at) ? res : (32'hDEAD0000 | k);
      #1 check({tag, ".start_wait"}, AluStart, 1'b0);
      check({tag, ".we_wait"}, WriteEn, 1'b0);
      if (k == done_at) begin
        check({tag, ".err_done"}, Error, 1'b0);
        break;
      end
      if (k == TO) begin
        saw_err = 1'b1;
        check({tag, ".err_timeout"}, Error, exp_err);
      end else begin
        check({tag, ".err_wait"}, Error, 1'b0);
      end
    end
    if (!saw_err) check({tag, ".err_expected"}, exp_err, 1'b0);
    @(posedge Clk); #1;
    AluDone = 1'b0;
    #1;
    if (exp_we) begin
      check({tag, ".we"}, WriteEn, 1'b1);
      check({tag, ".wnum"}, WriteRegNum, rd);
      check({tag, ".data"}, RegData, res);
      check({tag, ".ready_wb"}, InstReady, 1'b0);
      @(posedge Clk); #2;
      check({tag, ".we_off"}, WriteEn, 1'b0);
    end else begin
      check({tag, ".no_we"}, WriteEn, 1'b0);
    end
    check({tag, ".ready_after"}, InstReady, 1'b1);
    check({tag, ".err_after"}, Error, 1'b0);
    $display("op %s rs=%0d rt=%0d rd=%0d done_at=%0d A=%0h B=%0h RegData=%0h",
             tag, rs, rt, rd, done_at, AluA, AluB, RegData);
  endtask

  initial begin
    int acc0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[0] = 32'hFFFFFFFF; rf[1] = 32'd5; rf[2] = 32'd7; rf[4] = 32'h100; rf[5] = 32'h33;
    RstN = 1'b0; InstValid = 1'b0; InstRs = '0; InstRt = '0; InstRd = '0; InstOp = '0;
    AluResult = '0; AluDone = 1'b0;

    // The reset state is visible before any clock edge.
    #3;
    check("rst.alua", AluA, 32'd0);
    check("rst.regdata", RegData, 32'd0);
    check("rst.aluop", AluOp, 3'd0);
    check("rst.wnum", WriteRegNum, 5'd0);
    check("rst.start", AluStart, 1'b0);
    check("rst.we", WriteEn, 1'b0);
    check("rst.err", Error, 1'b0);
    check("rst.ready", InstReady, 1'b1);
    $display("reset checked");
    @(posedge Clk); @(posedge Clk); #1 RstN = 1'b1;
    @(posedge Clk); #2;

    do_op("basic",   5'd1, 5'd2, 5'd3,  3'd5, 32'd12,       1,  32'd5,     32'd7,     1'b1, 1'b0);
    do_op("late4",   5'd4, 5'd5, 5'd9,  3'd2, 32'hABCD,     4,  32'h100,   32'h33,    1'b1, 1'b0);
    do_op("timeout", 5'd1, 5'd4, 5'd10, 3'd1, 32'h5555,     0,  32'd5,     32'h100,   1'b0, 1'b1);
    do_op("coinc15", 5'd2, 5'd1, 5'd11, 3'd3, 32'h1234,     TO, 32'd7,     32'd5,     1'b1, 1'b0);
    do_op("done14",  5'd7, 5'd8, 5'd12, 3'd4, 32'hCAFE,     14, 32'h1007,  32'h1008,  1'b1, 1'b0);
`ifdef ZERO_REG_ENABLE_EN
    do_op("zero",    5'd0, 5'd0, 5'd0,  3'd6, 32'h9999,     1,  32'd0,     32'd0,     1'b0, 1'b0);
`else
    do_op("zero",    5'd0, 5'd0, 5'd0,  3'd6, 32'h9999,     1,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
`endif

    // Back-pressure: InstValid and AluDone are both held high. A new instruction
    // is accepted only every fifth edge, and AluDone has no effect outside WAIT.
    acc0 = accept_cnt;
    InstValid = 1'b1; InstRs = 5'd1; InstRt = 5'd2; InstRd = 5'd6; InstOp = 3'd2;
    AluDone = 1'b1; AluResult = 32'h77;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        @(posedge Clk); #2;
      end
      check("bp.ready", InstReady, (i % 5) == 0);
      check("bp.start", AluStart, (i % 5) == 2);
      check("bp.we", WriteEn, (i % 5) == 4);
      if (i == 9) InstValid = 1'b0;
    end
    @(posedge Clk); #2;
    check("bp.accepts", accept_cnt - acc0, 2);
    check("bp.wnum", WriteRegNum, 5'd6);
    check("bp.data", RegData, 32'h77);
    AluDone = 1'b0;
    $display("back-pressure accepts=%0d", accept_cnt - acc0);

    // Reset during WAIT: the outputs clear at once and the instruction is dropped.
    InstValid = 1'b1; InstRs = 5'd1; InstRt = 5'd2; InstRd = 5'd3; InstOp = 3'd3;
    @(posedge Clk); #1 InstValid = 1'b0;
    @(posedge Clk); @(posedge Clk); @(posedge Clk); #2;
    RstN = 1'b0;
    #1;
    check("rstw.alua", AluA, 32'd0);
    check("rstw.alub", AluB, 32'd0);
    check("rstw.regdata", RegData, 32'd0);
    check("rstw.aluop", AluOp, 3'd0);
    check("rstw.wnum", WriteRegNum, 5'd0);
    check("rstw.rnum1", ReadRegNum1, 5'd0);
    check("rstw.we", WriteEn, 1'b0);
    check("rstw.err", Error, 1'b0);
    @(posedge Clk); @(posedge Clk); #1 RstN = 1'b1;
    AluDone = 1'b1;
    #1 check("rstw.ready", InstReady, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #2;
      check("rstw.no_we", WriteEn, 1'b0);
      check("rstw.no_err", Error, 1'b0);
    end
    AluDone = 1'b0;
    $display("reset mid-WAIT checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
